// File: rtl/xadc_drp_sequencer.sv
// Scans NUM_CH consecutive XADC DRP status registers after each end-of-sequence
// and streams the 12-bit results with a channel tag over valid/ready.
// Optional DRP read timeout is enabled by defining DRP_TIMEOUT_EN.
module xadc_drp_sequencer #(
    parameter int unsigned NUM_CH    = 13,
    parameter logic [6:0]  BASE_ADDR = 7'h10,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        eos_in,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic [11:0] sample,
    output logic [3:0]  sample_ch,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        scan_done,
    output logic        overrun,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CH  = 4'(NUM_CH - 1);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [3:0]  ch_q;
    logic [6:0]  daddr_q;
    logic        den_q;
    logic [11:0] sample_q;
    logic [3:0]  sample_ch_q;
    logic        valid_q;
    logic        done_q;
    logic        overrun_q;
`ifdef DRP_TIMEOUT_EN
    logic [7:0]  tmo_cnt_q;
    logic        timeout_err_q;
`endif

    // Scan sequencer: one DRP read outstanding at a time, result held until accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            ch_q          <= 4'd0;
            daddr_q       <= BASE_ADDR;
            den_q         <= 1'b0;
            sample_q      <= 12'd0;
            sample_ch_q   <= 4'd0;
            valid_q       <= 1'b0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef DRP_TIMEOUT_EN
            tmo_cnt_q     <= 8'd0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            den_q  <= 1'b0;
            done_q <= 1'b0;
            if (eos_in && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (eos_in) begin
                        ch_q    <= 4'd0;
                        daddr_q <= BASE_ADDR;
                        den_q   <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // drdy coinciding with den is not a valid response
`ifdef DRP_TIMEOUT_EN
                    tmo_cnt_q <= 8'd1;
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (drp_drdy) begin
                        sample_q    <= drp_do[15:4];
                        sample_ch_q <= ch_q;
                        valid_q     <= 1'b1;
                        state_q     <= S_OUT;
                    end
`ifdef DRP_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_LAST) begin
                        sample_q      <= 12'h000;
                        sample_ch_q   <= ch_q;
                        valid_q       <= 1'b1;
                        timeout_err_q <= 1'b1;
                        state_q       <= S_OUT;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
`endif
                end
                S_OUT: begin
                    if (sample_ready) begin
                        valid_q <= 1'b0;
                        if (ch_q < LAST_CH) begin
                            ch_q    <= ch_q + 4'd1;
                            daddr_q <= BASE_ADDR + 7'(ch_q) + 7'd1;
                            den_q   <= 1'b1;
                            state_q <= S_ISSUE;
                        end else begin
                            done_q  <= 1'b1;
                            ch_q    <= 4'd0;
                            daddr_q <= BASE_ADDR;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign drp_daddr    = daddr_q;
    assign drp_den      = den_q;
    assign sample       = sample_q;
    assign sample_ch    = sample_ch_q;
    assign sample_valid = valid_q;
    assign scan_done    = done_q;
    assign overrun      = overrun_q;

    // Status nibble of drp_do carries no sample data
    logic unused_bits;
`ifdef DRP_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
    assign unused_bits = ^drp_do[3:0];
`else
    assign timeout_err = 1'b0;
    assign unused_bits = ^{drp_do[3:0], TMO_LAST};
`endif

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Self-checking bench for xadc_drp_sequencer: XADC DRP responder model plus a
// scan-order reference queue; directed steps with randomized data/delays/ready.
module tb_xadc_drp_sequencer;

    localparam int unsigned NUM_CH = 13;
    localparam logic [6:0]  BASE   = 7'h10;

    logic        clk = 1'b0;
    logic        rst;
    logic        eos_in = 1'b0;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic [15:0] drp_do = 16'h0;
    logic        drp_drdy = 1'b0;
    logic [11:0] sample;
    logic [3:0]  sample_ch;
    logic        sample_valid;
    logic        sample_ready = 1'b1;
    logic        scan_done;
    logic        overrun;
    logic        timeout_err;

    xadc_drp_sequencer #(.NUM_CH(NUM_CH), .BASE_ADDR(BASE), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .eos_in(eos_in),
        .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_do(drp_do), .drp_drdy(drp_drdy),
        .sample(sample), .sample_ch(sample_ch), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .scan_done(scan_done),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: expected (channel, sample) per read, in scan order
    typedef struct packed { logic [3:0] ch; logic [11:0] smp; } exp_t;
    exp_t exp_q[$];

    int  rd_idx = 0;
    int  den_total = 0;
    bit  pending = 1'b0;
    int  cd = 0;
    logic [15:0] pend_data = 16'h0;
    bit  toggle_mode = 1'b0;
    bit  fixed_data = 1'b1;
    bit  rand_ready = 1'b0;
    int  dmin = 3;
    int  dmax = 3;

    // XADC DRP port model
    always @(posedge clk) begin
        logic [15:0] d16;
        exp_t e;
        #1;
        drp_do = 16'($urandom);
        if (toggle_mode) drp_drdy = ~drp_drdy;
        else drp_drdy = 1'b0;
        if (rst && drp_den) begin
            check("den_one_outstanding", 32'(pending), 32'd0);
            check("den_addr", 32'(drp_daddr), 32'(7'(BASE + rd_idx)));
            d16 = fixed_data ? {12'(rd_idx + 1), 4'h0} : 16'($urandom);
            e.ch = 4'(rd_idx);
            e.smp = d16[15:4];
            exp_q.push_back(e);
            rd_idx = (rd_idx + 1) % NUM_CH;
            den_total++;
            pending = 1'b1;
            cd = $urandom_range(dmax, dmin);
            pend_data = d16;
        end else if (pending) begin
            cd--;
            if (cd == 0) begin
                drp_drdy = 1'b1;
                drp_do = pend_data;
                pending = 1'b0;
            end
        end
        if (!rst) begin
            check("den_in_reset", 32'(drp_den), 32'd0);
            rd_idx = 0;
            exp_q.delete();
        end
    end

    // Output monitor: transfers, hold under backpressure, scan_done alignment
    int unsigned xfer_total = 0;
    int unsigned done_total = 0;
    bit prev_stall = 1'b0;
    bit final_xfer = 1'b0;
    logic [11:0] prev_s = 12'h0;
    logic [3:0]  prev_c = 4'h0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            prev_stall = 1'b0;
            final_xfer = 1'b0;
        end else begin
            if (final_xfer || scan_done) check("scan_done_align", 32'(scan_done), 32'(final_xfer));
            if (scan_done) done_total++;
            final_xfer = 1'b0;
            if (prev_stall) begin
                check("hold_valid", 32'(sample_valid), 32'd1);
                check("hold_sample", 32'(sample), 32'(prev_s));
                check("hold_ch", 32'(sample_ch), 32'(prev_c));
            end
            if (sample_valid && sample_ready) begin
                if (exp_q.size() == 0) begin
                    check("xfer_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_sample", 32'(sample), 32'(e.smp));
                    check("xfer_ch", 32'(sample_ch), 32'(e.ch));
                    final_xfer = (e.ch == 4'(NUM_CH - 1));
                    xfer_total++;
                end
            end
            prev_stall = sample_valid && !sample_ready;
            prev_s = sample;
            prev_c = sample_ch;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) sample_ready = 1'($urandom);
    endtask

    task automatic start_scan();
        eos_in = 1'b1;
        step();
        eos_in = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!scan_done && cycles < 3000) begin
            step();
            cycles++;
        end
        check("scan_done_reached", 32'(scan_done), 32'd1);
    endtask

    task automatic wait_den_addr(input logic [6:0] a);
        int n = 0;
        while (!(drp_den && drp_daddr == a) && n < 1000) begin
            step();
            n++;
        end
        check("reach_den_addr", 32'(drp_den && drp_daddr == a), 32'd1);
    endtask

    initial begin
        int c;
        int den0;
        int xf0;
        int dn0;
        int n;
        logic [11:0] hold;

        // Reset with activity on the inputs
        rst = 1'b1;
        #1 rst = 1'b0;
        toggle_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            eos_in = (i % 2 == 0);
            check("rst_outputs_zero",
                  32'({drp_den, sample_valid, scan_done, overrun, timeout_err, sample, sample_ch}), 32'd0);
            check("rst_daddr", 32'(drp_daddr), 32'(BASE));
        end
        eos_in = 1'b0;
        toggle_mode = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        step();
        check("post_rst_idle", 32'({drp_den, sample_valid}), 32'd0);
        check("post_rst_daddr", 32'(drp_daddr), 32'(BASE));

        // Full scan, fixed data, 3-cycle DRP latency, ready tied high
        den0 = den_total; xf0 = int'(xfer_total); dn0 = int'(done_total);
        start_scan();
        check("first_den", 32'(drp_den), 32'd1);
        check("first_daddr", 32'(drp_daddr), 32'(BASE));
        wait_done(c);
        check("scan_latency", 32'(c + 1), 32'(5 * NUM_CH + 1));
        step();
        check("scan_done_one_cycle", 32'(scan_done), 32'd0);
        check("full_den_count", 32'(den_total - den0), 32'(NUM_CH));
        check("full_xfer_count", 32'(int'(xfer_total) - xf0), 32'(NUM_CH));
        check("full_done_count", 32'(int'(done_total) - dn0), 32'd1);

        // Backpressure on channel 4, random data
        fixed_data = 1'b0;
        start_scan();
        n = 0;
        while (!(sample_valid && sample_ch == 4'd4) && n < 500) begin
            step();
            n++;
        end
        check("bp_reach_ch4", 32'(sample_valid && sample_ch == 4'd4), 32'd1);
        sample_ready = 1'b0;
        hold = sample;
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_sample_stable", 32'(sample), 32'(hold));
            check("bp_ch_stable", 32'(sample_ch), 32'd4);
            check("bp_no_den", 32'(drp_den), 32'd0);
        end
        sample_ready = 1'b1;
        step();
        check("bp_next_den", 32'(drp_den), 32'd1);
        check("bp_next_daddr", 32'(drp_daddr), 32'h15);
        wait_done(c);
        step();

        // Overrun during channel 6, random delays and random ready
        dmin = 1; dmax = 6; rand_ready = 1'b1;
        den0 = den_total;
        start_scan();
        wait_den_addr(7'h16);
        step();
        eos_in = 1'b1;
        step();
        eos_in = 1'b0;
        check("overrun_set", 32'(overrun), 32'd1);
        wait_done(c);
        check("overrun_scan_reads", 32'(den_total - den0), 32'(NUM_CH));
        step();
        den0 = den_total;
        start_scan();
        check("after_overrun_daddr", 32'(drp_daddr), 32'(BASE));
        wait_done(c);
        check("after_overrun_reads", 32'(den_total - den0), 32'(NUM_CH));
        check("overrun_sticky", 32'(overrun), 32'd1);
        rand_ready = 1'b0;
        sample_ready = 1'b1;
        dmin = 3; dmax = 3;
        step();

        // Asynchronous reset while waiting on channel 8
        start_scan();
        wait_den_addr(7'h18);
        step();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_outputs", 32'({drp_den, sample_valid, scan_done, overrun}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("stale_drdy_ignored", 32'({drp_den, sample_valid}), 32'd0);
        end
        den0 = den_total; xf0 = int'(xfer_total);
        start_scan();
        check("restart_daddr", 32'(drp_daddr), 32'(BASE));
        wait_done(c);
        check("restart_reads", 32'(den_total - den0), 32'(NUM_CH));
        check("restart_xfers", 32'(int'(xfer_total) - xf0), 32'(NUM_CH));
        step();

        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        check("timeout_err_zero", 32'(timeout_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
